// File: rtl/wb_dcache_flush_ctrl_if.sv
// Flush-sequencer bundle: flush request/ack, tag-array read port, writeback
// channel and invalidate port shared between the sequencer and the dcache.
interface wb_dcache_flush_ctrl_if #(
    parameter int NUM_SETS   = 256,
    parameter int NUM_WAYS   = 8,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 56
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - SET_W - OFF_W;
    localparam int CNT_W = $clog2(NUM_SETS * NUM_WAYS + 1);

    logic              flush_i;
    logic              busy_o;
    logic              flush_ack_o;
    logic [SET_W-1:0]  set_o;
    logic [WAY_W-1:0]  way_o;
    logic              rd_req_o;
    logic              rd_gnt_i;
    logic              rd_rvalid_i;
    logic              rd_valid_i;
    logic              rd_dirty_i;
    logic [TAG_W-1:0]  rd_tag_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic              wb_done_i;
    logic              inv_req_o;
    logic              inv_gnt_i;
    logic [CNT_W-1:0]  wb_count_o;

    modport master (
        input  flush_i, rd_gnt_i, rd_rvalid_i, rd_valid_i, rd_dirty_i, rd_tag_i,
               wb_ready_i, wb_done_i, inv_gnt_i,
        output busy_o, flush_ack_o, set_o, way_o, rd_req_o, wb_valid_o,
               wb_addr_o, inv_req_o, wb_count_o
    );

    modport slave (
        output flush_i, rd_gnt_i, rd_rvalid_i, rd_valid_i, rd_dirty_i, rd_tag_i,
               wb_ready_i, wb_done_i, inv_gnt_i,
        input  busy_o, flush_ack_o, set_o, way_o, rd_req_o, wb_valid_o,
               wb_addr_o, inv_req_o, wb_count_o
    );
endinterface

// File: rtl/wb_dcache_flush_ctrl.sv
// Walks every set/way of the write-back dcache, writing back dirty lines and
// invalidating valid ones, then pulses flush_ack_o once.
module wb_dcache_flush_ctrl #(
    parameter int NUM_SETS   = 256,
    parameter int NUM_WAYS   = 8,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 56
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    wb_dcache_flush_ctrl_if.master  bus
);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int CNT_W  = $clog2(NUM_SETS * NUM_WAYS + 1);
    localparam int LINE_W = SET_W + WAY_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WB_REQ, S_WB_WAIT, S_INV, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [LINE_W-1:0] line_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [CNT_W-1:0]  count_reg;

    logic start, advance, accept, last_line, rd_take;
    state_t adv_target;

    assign start      = (state_reg == S_IDLE) && bus.flush_i;
    assign rd_take    = (state_reg == S_RD_WAIT) && bus.rd_rvalid_i;
    assign accept     = (state_reg == S_WB_REQ) && bus.wb_ready_i;
    assign advance    = (rd_take && !bus.rd_valid_i) ||
                        ((state_reg == S_INV) && bus.inv_gnt_i);
    // {set, way} is one counter: the way field carries into the set field.
    assign last_line  = &line_reg;
    assign adv_target = last_line ? S_DONE : S_RD_REQ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (bus.flush_i) state_next = S_RD_REQ;
            S_RD_REQ:  if (bus.rd_gnt_i) state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.rd_rvalid_i) begin
                    if (!bus.rd_valid_i)     state_next = adv_target;
                    else if (bus.rd_dirty_i) state_next = S_WB_REQ;
                    else                     state_next = S_INV;
                end
            end
            S_WB_REQ:  if (bus.wb_ready_i) state_next = S_WB_WAIT;
            S_WB_WAIT: if (bus.wb_done_i) state_next = S_INV;
            S_INV:     if (bus.inv_gnt_i) state_next = adv_target;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_reg  <= '0;
            tag_reg   <= '0;
            count_reg <= '0;
        end else begin
            if (start) begin
                line_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (advance) line_reg <= line_reg + LINE_W'(1);
                if (accept)  count_reg <= count_reg + CNT_W'(1);
            end
            if (rd_take) tag_reg <= bus.rd_tag_i;
        end
    end

    always_comb begin
        bus.busy_o      = (state_reg != S_IDLE);
        bus.rd_req_o    = (state_reg == S_RD_REQ);
        bus.wb_valid_o  = (state_reg == S_WB_REQ);
        bus.inv_req_o   = (state_reg == S_INV);
        bus.flush_ack_o = (state_reg == S_DONE);
    end

    assign bus.set_o      = line_reg[LINE_W-1:WAY_W];
    assign bus.way_o      = line_reg[WAY_W-1:0];
    assign bus.wb_addr_o  = {tag_reg, line_reg[LINE_W-1:WAY_W], {OFF_W{1'b0}}};
    assign bus.wb_count_o = count_reg;
endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Randomized bench for wb_dcache_flush_ctrl: a cache/memory responder, a
// line-walk reference model feeding scoreboard queues, and a negedge monitor.
module tb_wb_dcache_flush_ctrl;
    localparam int NS = 4, NW = 2, LB = 16, AW = 16;
    localparam int SET_W = $clog2(NS), OFF_W = $clog2(LB);
    localparam int TAG_W = AW - SET_W - OFF_W;
    localparam int NL = NS * NW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_dcache_flush_ctrl_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .LINE_BYTES(LB), .ADDR_W(AW)) bus ();

    wb_dcache_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .LINE_BYTES(LB), .ADDR_W(AW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int     rd_q[$];
    int     inv_q[$];
    int     ack_q[$];
    longint wb_q[$];

    bit               c_valid[NL];
    bit               c_dirty[NL];
    logic [TAG_W-1:0] c_tag[NL];
    bit               m_valid[NL];
    bit               m_dirty[NL];
    logic [TAG_W-1:0] m_tag[NL];

    int mode = 0;
    bit wb_hold = 0;
    bit wb_pend = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one flush computed line by line from the cache contents.
    function automatic int ref_flush();
        int cnt = 0;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                int l = s * NW + w;
                rd_q.push_back(l);
                if (m_valid[l]) begin
                    if (m_dirty[l]) begin
                        wb_q.push_back((longint'(m_tag[l]) << (SET_W + OFF_W)) + longint'(s * LB));
                        cnt++;
                    end
                    inv_q.push_back(l);
                end
                m_valid[l] = 0;
                m_dirty[l] = 0;
            end
        end
        ack_q.push_back(cnt);
        return cnt;
    endfunction

    task automatic set_line(input int l, input bit v, input bit d, input logic [TAG_W-1:0] t);
        c_valid[l] = v; c_dirty[l] = d; c_tag[l] = t;
        m_valid[l] = v; m_dirty[l] = d; m_tag[l] = t;
    endtask

    task automatic load(input int kind);
        for (int l = 0; l < NL; l++) begin
            bit v;
            v = (kind == 1) || (kind == 2 && $urandom_range(0, 3) != 0);
            set_line(l, v, v && kind == 2 && $urandom_range(0, 1) == 1, TAG_W'($urandom));
        end
    endtask

    // Cache / memory responder.
    bit p_rd, p_wb, p_inv;
    int p_line, rd_line, rd_dly, wb_dly, rd_bp, wb_bp, inv_bp;
    bit rd_pend;
    initial begin
        bus.rd_gnt_i = 0; bus.rd_rvalid_i = 0; bus.rd_valid_i = 0; bus.rd_dirty_i = 0;
        bus.rd_tag_i = '0; bus.wb_ready_i = 0; bus.wb_done_i = 0; bus.inv_gnt_i = 0;
        forever begin
            @(posedge clk); #1;
            bus.rd_rvalid_i = 0;
            bus.wb_done_i   = 0;
            if (!rst_n) begin
                p_rd = 0; p_wb = 0; p_inv = 0; rd_pend = 0; wb_pend = 0;
                rd_bp = 0; wb_bp = 0; inv_bp = 0;
            end else begin
                if (p_rd && bus.rd_gnt_i) begin
                    rd_pend = 1; rd_line = p_line; rd_bp = 0;
                    rd_dly = (mode == 0) ? 0 : $urandom_range(0, 3);
                end
                if (p_inv && bus.inv_gnt_i) begin
                    c_valid[p_line] = 0; c_dirty[p_line] = 0; inv_bp = 0;
                end
                if (p_wb && bus.wb_ready_i) begin
                    wb_pend = 1; wb_bp = 0;
                    wb_dly = (mode == 0) ? 0 : $urandom_range(0, 4);
                end
                bus.rd_valid_i = 1'($urandom);
                bus.rd_dirty_i = 1'($urandom);
                bus.rd_tag_i   = TAG_W'($urandom);
                if (rd_pend) begin
                    if (rd_dly == 0) begin
                        bus.rd_rvalid_i = 1;
                        bus.rd_valid_i  = c_valid[rd_line];
                        bus.rd_dirty_i  = c_dirty[rd_line];
                        bus.rd_tag_i    = c_tag[rd_line];
                        rd_pend = 0;
                    end else rd_dly--;
                end
                if (wb_pend) begin
                    if (!wb_hold) begin
                        if (wb_dly == 0) begin bus.wb_done_i = 1; wb_pend = 0; end
                        else wb_dly--;
                    end
                end else if (mode != 0 && $urandom_range(0, 7) == 0) begin
                    bus.wb_done_i = 1;
                end
                case (mode)
                    0: begin bus.rd_gnt_i = 1; bus.wb_ready_i = 1; bus.inv_gnt_i = 1; end
                    1: begin
                        bus.rd_gnt_i   = ($urandom_range(0, 3) != 0);
                        bus.wb_ready_i = ($urandom_range(0, 3) != 0);
                        bus.inv_gnt_i  = ($urandom_range(0, 3) != 0);
                    end
                    default: begin
                        bus.rd_gnt_i   = bus.rd_req_o && rd_bp >= 5;
                        bus.wb_ready_i = bus.wb_valid_o && wb_bp >= 5;
                        bus.inv_gnt_i  = bus.inv_req_o && inv_bp >= 5;
                        if (bus.rd_req_o && rd_bp < 5) rd_bp++;
                        if (bus.wb_valid_o && wb_bp < 5) wb_bp++;
                        if (bus.inv_req_o && inv_bp < 5) inv_bp++;
                    end
                endcase
                p_rd   = bus.rd_req_o;
                p_wb   = bus.wb_valid_o;
                p_inv  = bus.inv_req_o;
                p_line = int'(bus.set_o) * NW + int'(bus.way_o);
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks request stability.
    bit          h_rd, h_wb, h_inv, wb_out;
    int          h_rd_line, h_inv_line, cur_line;
    logic [AW-1:0] h_addr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h_rd = 0; h_wb = 0; h_inv = 0; wb_out = 0;
            end else begin
                cur_line = int'(bus.set_o) * NW + int'(bus.way_o);
                if (h_rd) begin
                    check("rd_req_held", 64'(bus.rd_req_o), 64'(1));
                    check("rd_line_stable", 64'(cur_line), 64'(h_rd_line));
                end
                if (h_wb) begin
                    check("wb_valid_held", 64'(bus.wb_valid_o), 64'(1));
                    check("wb_addr_stable", 64'(bus.wb_addr_o), 64'(h_addr));
                end
                if (h_inv) begin
                    check("inv_req_held", 64'(bus.inv_req_o), 64'(1));
                    check("inv_line_stable", 64'(cur_line), 64'(h_inv_line));
                end
                if (wb_out && bus.wb_done_i) wb_out = 0;
                if (bus.inv_req_o) check("inv_before_wb_done", 64'(wb_out), 64'(0));
                if (bus.rd_req_o && bus.rd_gnt_i) begin
                    if (rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                    else check("rd_line", 64'(cur_line), 64'(rd_q.pop_front()));
                end
                if (bus.wb_valid_o && bus.wb_ready_i) begin
                    wb_out = 1;
                    if (wb_q.size() == 0) check("wb_unexpected", 64'(1), 64'(0));
                    else check("wb_addr", 64'(bus.wb_addr_o), 64'(wb_q.pop_front()));
                end
                if (bus.inv_req_o && bus.inv_gnt_i) begin
                    if (inv_q.size() == 0) check("inv_unexpected", 64'(1), 64'(0));
                    else check("inv_line", 64'(cur_line), 64'(inv_q.pop_front()));
                end
                if (bus.flush_ack_o) begin
                    if (ack_q.size() == 0) check("ack_unexpected", 64'(1), 64'(0));
                    else check("ack_wb_count", 64'(bus.wb_count_o), 64'(ack_q.pop_front()));
                end
                h_rd = bus.rd_req_o && !bus.rd_gnt_i;
                h_wb = bus.wb_valid_o && !bus.wb_ready_i;
                h_inv = bus.inv_req_o && !bus.inv_gnt_i;
                h_rd_line = cur_line; h_inv_line = cur_line; h_addr = bus.wb_addr_o;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", 64'(bus.busy_o), 64'(0));
        check("rst_ack", 64'(bus.flush_ack_o), 64'(0));
        check("rst_rd_req", 64'(bus.rd_req_o), 64'(0));
        check("rst_wb_valid", 64'(bus.wb_valid_o), 64'(0));
        check("rst_inv_req", 64'(bus.inv_req_o), 64'(0));
        check("rst_set", 64'(bus.set_o), 64'(0));
        check("rst_way", 64'(bus.way_o), 64'(0));
        check("rst_wb_addr", 64'(bus.wb_addr_o), 64'(0));
        check("rst_wb_count", 64'(bus.wb_count_o), 64'(0));
    endtask

    task automatic start_flush(input bit hold);
        bus.flush_i = 1;
        @(posedge clk); #1;
        if (!hold) bus.flush_i = 0;
        check("busy_after_start", 64'(bus.busy_o), 64'(1));
        check("rd_req_after_start", 64'(bus.rd_req_o), 64'(1));
    endtask

    task automatic wait_ack(input int exp_cyc);
        int cyc = 1;
        while (!bus.flush_ack_o && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ack_seen", 64'(bus.flush_ack_o), 64'(1));
        if (exp_cyc > 0) check("ack_cycle", 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic post_checks();
        int nv = 0;
        @(posedge clk); #1;
        for (int l = 0; l < NL; l++) nv += int'(c_valid[l]);
        check("cache_all_invalid", 64'(nv), 64'(0));
        check("scoreboard_drained", 64'(rd_q.size() + wb_q.size() + inv_q.size() + ack_q.size()), 64'(0));
        check("idle_after_flush", 64'(bus.busy_o), 64'(0));
    endtask

    initial begin
        int cnt, acks, cyc;
        bus.flush_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1;
        @(posedge clk); #1;
        check("idle_without_flush", 64'(bus.busy_o), 64'(0));

        // Empty cache, immediate handshakes.
        mode = 0; load(0); void'(ref_flush());
        start_flush(0); wait_ack(1 + 2 * NL); post_checks();
        check("empty_wb_count", 64'(bus.wb_count_o), 64'(0));

        // All lines valid and clean.
        load(1); void'(ref_flush());
        start_flush(0); wait_ack(1 + 3 * NL); post_checks();

        // One dirty line at (2,1), tag 0x123.
        mode = 1; load(1); set_line(2 * NW + 1, 1, 1, TAG_W'(12'h123)); void'(ref_flush());
        start_flush(0); wait_ack(0); post_checks();
        check("dirty_wb_count_hold", 64'(bus.wb_count_o), 64'(1));

        // Five-cycle backpressure on every request.
        mode = 2; load(2); cnt = ref_flush();
        start_flush(0); wait_ack(0); post_checks();
        check("bp_wb_count", 64'(bus.wb_count_o), 64'(cnt));

        // Random contents and handshakes.
        mode = 1;
        for (int it = 0; it < 6; it++) begin
            load(2); void'(ref_flush());
            start_flush(0); wait_ack(0); post_checks();
        end

        // Reset while a writeback is outstanding.
        wb_hold = 1; load(1); set_line(3, 1, 1, TAG_W'($urandom)); void'(ref_flush());
        start_flush(0);
        cyc = 0;
        while (!wb_pend && cyc < 500) begin @(posedge clk); #1; cyc++; end
        check("reached_wb_wait", 64'(wb_pend), 64'(1));
        rst_n = 0; #1;
        check_reset_outputs();
        rd_q.delete(); wb_q.delete(); inv_q.delete(); ack_q.delete();
        wb_hold = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_ack_in_reset", 64'(bus.flush_ack_o), 64'(0));
        end
        rst_n = 1;
        for (int l = 0; l < NL; l++) begin
            m_valid[l] = c_valid[l]; m_dirty[l] = c_dirty[l]; m_tag[l] = c_tag[l];
        end
        check("dirty_line_kept", 64'(c_dirty[3]), 64'(1));
        @(posedge clk); #1;
        void'(ref_flush());
        start_flush(0); wait_ack(0); post_checks();

        // flush_i pulses while busy are ignored.
        load(2); void'(ref_flush());
        start_flush(0);
        for (int i = 0; i < 10; i++) begin
            bus.flush_i = 1'(i % 2);
            @(posedge clk); #1;
        end
        bus.flush_i = 0;
        wait_ack(0);
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            acks += int'(bus.flush_ack_o);
        end
        check("single_ack", 64'(acks), 64'(0));
        check("idle_after_pulses", 64'(bus.busy_o), 64'(0));
        post_checks();

        // flush_i held through DONE restarts from IDLE.
        mode = 0; load(2); set_line(0, 1, 1, TAG_W'($urandom));
        cnt = ref_flush(); void'(ref_flush());
        start_flush(1); wait_ack(0);
        @(posedge clk); #1;
        check("held_idle_gap", 64'(bus.busy_o), 64'(0));
        check("held_count_kept", 64'(bus.wb_count_o), 64'(cnt));
        @(posedge clk); #1;
        check("held_restart_busy", 64'(bus.busy_o), 64'(1));
        check("held_count_cleared", 64'(bus.wb_count_o), 64'(0));
        bus.flush_i = 0;
        wait_ack(1 + 2 * NL); post_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_dcache_flush_ctrl.md
# wb_dcache_flush_ctrl

Sequencer that walks every set/way of the write-back data cache on a flush request (fence.i / sfence / debug entry), writes back dirty lines to memory and invalidates every valid line. Sits beside the WB dcache controller: borrows the tag/state array read port and the invalidate port through request/grant handshakes, and drives the miss-handler writeback channel. Issues one completion pulse to the controller when the whole cache is clean and invalid.

## Interface
- NUM_SETS, 256, number of cache sets (power of two, ≥2)
- NUM_WAYS, 8, associativity (power of two, ≥2)
- LINE_BYTES, 16, line size in bytes (power of two)
- ADDR_W, 56, physical address width
- Derived: SET_W = $clog2(NUM_SETS), WAY_W = $clog2(NUM_WAYS), OFF_W = $clog2(LINE_BYTES), TAG_W = ADDR_W-SET_W-OFF_W, CNT_W = $clog2(NUM_SETS*NUM_WAYS+1)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  flush request, sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- flush_ack_o  out  1  one-cycle completion pulse
- set_o  out  SET_W  set index of the line being processed
- way_o  out  WAY_W  way index of the line being processed
- rd_req_o  out  1  tag/state read request
- rd_gnt_i  in  1  read grant
- rd_rvalid_i  in  1  read data valid (any cycle after grant)
- rd_valid_i  in  1  line valid bit
- rd_dirty_i  in  1  line dirty bit
- rd_tag_i  in  TAG_W  line tag
- wb_valid_o  out  1  writeback request
- wb_ready_i  in  1  writeback accepted
- wb_addr_o  out  ADDR_W  line address {tag, set, OFF_W'0}
- wb_done_i  in  1  memory acknowledged the writeback
- inv_req_o  out  1  invalidate request for set_o/way_o
- inv_gnt_i  in  1  invalidate grant
- wb_count_o  out  CNT_W  lines written back in the current/last flush

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WB_REQ, WB_WAIT, INV, DONE.
- IDLE: flush_i=1 → clear set/way counters and wb_count_o, go RD_REQ.
- RD_REQ: rd_req_o=1 held until rd_gnt_i; on grant → RD_WAIT.
- RD_WAIT: on rd_rvalid_i, latch tag; !valid → ADVANCE; valid & dirty → WB_REQ; valid & !dirty → INV.
- WB_REQ: wb_valid_o=1, wb_addr_o stable, held until wb_ready_i; on accept → WB_WAIT, wb_count_o+1.
- WB_WAIT: wait wb_done_i → INV. (wb_done_i outside WB_WAIT ignored.)
- INV: inv_req_o=1 held until inv_gnt_i → ADVANCE.
- ADVANCE (transition action, not a state): way+1; at way=NUM_WAYS-1 wrap way to 0 and set+1; if set=NUM_SETS-1 and way=NUM_WAYS-1 → DONE, else → RD_REQ.
- DONE: flush_ack_o=1 for exactly one cycle → IDLE.
- set_o/way_o stable from RD_REQ entry until ADVANCE; only change on ADVANCE or flush start.
- flush_i while busy is ignored (not queued); a flush_i held high through DONE starts a new flush from IDLE the cycle after.
- Order of traversal: set-major, way-minor (set0/way0, set0/way1, …).

## Timing
- Reset values: busy_o=0, flush_ack_o=0, rd_req_o=0, wb_valid_o=0, inv_req_o=0, set_o=0, way_o=0, wb_addr_o=0, wb_count_o=0, state IDLE.
- All outputs registered or decoded from state registers only; no combinational path input→output.
- flush_i=1 at edge N → busy_o=1, rd_req_o=1 in cycle N+1.
- Minimum cost per line (grants/rvalid immediate): invalid 2 cycles; clean valid 3; dirty 3 + wb latency.
- Empty cache with immediate handshakes: flush_ack_o in cycle 1+2·NUM_SETS·NUM_WAYS after flush_i sample.
- Reset mid-flush: immediate return to IDLE, all outputs to reset values, no flush_ack_o; partially walked lines keep their state.
- wb_count_o holds its value after DONE until next flush start; never wraps (max NUM_SETS·NUM_WAYS fits CNT_W).

## Test plan
- NUM_SETS=4, NUM_WAYS=2, all lines invalid, grants/rvalid tied 1 → rd_req_o for 8 lines in order (0,0),(0,1),(1,0)…(3,1), no inv/wb, flush_ack_o in cycle 17, wb_count_o=0.
- Same config, all valid clean → 8 inv_req_o pulses with matching set/way, no wb_valid_o, ack at cycle 25.
- Line (2,1) dirty, tag 0x123 → single wb_valid_o with wb_addr_o={0x123, 2'd2, 4'h0}, INV only after wb_done_i, wb_count_o=1.
- Backpressure: rd_gnt_i, wb_ready_i, inv_gnt_i each low 5 cycles → requests held high, set_o/way_o/wb_addr_o stable, result identical to no-backpressure run.
- rst_ni low during WB_WAIT → all outputs 0 next cycle, no flush_ack_o; fresh flush after reset completes normally.
- flush_i pulsed while busy → ignored, exactly one flush_ack_o; flush_i held high → second flush starts cycle after DONE, wb_count_o cleared.
